muldiv_execute_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It consumes the operands, funct3 and destination register latched into execute and computes the result over multiple cycles. It raises a stall so the hazard unit holds IF/ID/EX while it works, then presents a registered result for the EX/MEM register to capture.

---
 rtl/muldiv_execute_unit.sv | 157 +++++++++++++++
 tb/tb_muldiv_execute_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_execute_unit.sv
// muldiv_execute_unit: iterative RV32M multiply/divide for the execute stage.
// One radix-2 step per cycle on unsigned magnitudes, with sign fixup folded
// into the final step so result_o is registered on the edge entering DONE.
module muldiv_execute_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   a_q, b_q;     // raw operands as accepted
    logic [XLEN-1:0]   ma, mb;       // operand magnitudes
    logic              neg_q;        // product/quotient must be negated
    logic              nrem_q;       // remainder takes dividend's (negative) sign
    logic [2*XLEN-1:0] acc;          // product, or {remainder, quotient}
    logic [CW-1:0]     cnt;

    logic              is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [2*XLEN-1:0] mul_step, div_step, acc_nxt, prod;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   trial, quo, rem, final_res, special_res;

    // Operand sign classification and the two PREP-time special cases
    always_comb begin
        is_div   = f3_q[2];
        sgn_a    = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
        sgn_b    = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
        a_neg    = sgn_a && a_q[XLEN-1];
        b_neg    = sgn_b && b_q[XLEN-1];
        div_zero = is_div && (b_q == '0);
        div_ovf  = is_div && !f3_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        // div-by-zero: quotient all ones, remainder = dividend; overflow: quotient = min int, remainder 0
        if (div_zero)
            special_res = f3_q[1] ? a_q : '1;
        else
            special_res = f3_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One radix-2 step: MSB-first shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_step = {acc[2*XLEN-2:0], 1'b0} + (mb[cnt] ? {{XLEN{1'b0}}, ma} : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], ma[cnt]};
        // when rem_sh >= mb the difference is < mb, so XLEN bits are enough
        trial    = rem_sh[XLEN-1:0] - mb;
        if (rem_sh >= {1'b0, mb})
            div_step = {trial, acc[XLEN-2:0], 1'b1};
        else
            div_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        acc_nxt = is_div ? div_step : mul_step;
    end

    // Sign fixup and result selection applied to the value produced by the last step
    always_comb begin
        prod = neg_q  ? -acc_nxt : acc_nxt;
        quo  = neg_q  ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem  = nrem_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quo;
            default:                final_res = rem;
        endcase
    end

    // Control FSM plus datapath registers; flush drops the op without touching result_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            f3_q     <= '0;
            rd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ma       <= '0;
            mb       <= '0;
            neg_q    <= 1'b0;
            nrem_q   <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            result_o <= '0;
            rd_o     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (valid_i && !flush_i) begin
                        f3_q  <= funct3_i;
                        rd_q  <= rd_i;
                        a_q   <= op_a_i;
                        b_q   <= op_b_i;
                        state <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        ma     <= a_neg ? -a_q : a_q;
                        mb     <= b_neg ? -b_q : b_q;
                        neg_q  <= a_neg ^ b_neg;
                        nrem_q <= a_neg;
                        acc    <= '0;
                        cnt    <= CW'(XLEN-1);
                        if (div_zero || div_ovf) begin
                            result_o <= special_res;
                            rd_o     <= rd_q;
                            state    <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            result_o <= final_res;
                            rd_o     <= rd_q;
                            state    <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs derived from registered state; stall covers the accept cycle too
    always_comb begin
        busy_o  = (state != S_IDLE);
        done_o  = (state == S_DONE);
        stall_o = ((state == S_IDLE) && valid_i && !flush_i) || (state == S_PREP) || (state == S_CALC);
    end

endmodule

// File: tb/tb_muldiv_execute_unit.sv
// Directed bench for muldiv_execute_unit: hand-computed results, latencies,
// stall shape, flush abort, async reset and back-to-back issue.
module tb_muldiv_execute_unit;

    logic        clk, rst, valid_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i, op_b_i;
    logic [4:0]  rd_i;
    logic        busy_o, stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    muldiv_execute_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .funct3_i(funct3_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .rd_i(rd_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Issue one op from IDLE and wait for done_o; checks latency, result, rd,
    // stall shape, then steps once more and checks the return to IDLE.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, output int done_cyc);
        int lat = 0;
        int stalls = 0;
        valid_i = 1'b1; funct3_i = f3; op_a_i = a; op_b_i = b; rd_i = rd;
        #1;
        if (stall_o) stalls++;
        step();
        valid_i = 1'b0; op_a_i = 32'hDEAD_BEEF; op_b_i = 32'h1234_5678; rd_i = 5'd0;
        lat = 1;
        while (!done_o && lat < 100) begin
            if (stall_o) stalls++;
            step();
            lat++;
        end
        done_cyc = cyc;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " result"}, result_o, exp);
        chk({tag, " rd"}, {27'd0, rd_o}, {27'd0, rd});
        chk({tag, " stall in DONE"}, {31'd0, stall_o}, 32'd0);
        chk({tag, " stall cycles"}, stalls, exp_lat);
        step();
        chk({tag, " done drops"}, {31'd0, done_o}, 32'd0);
        chk({tag, " busy drops"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int d1, d2, dummy;
        logic saw_done;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; funct3_i = 3'b000;
        op_a_i = '0; op_b_i = '0; rd_i = '0;
        #3;
        chk("reset busy", {31'd0, busy_o}, 32'd0);
        chk("reset done", {31'd0, done_o}, 32'd0);
        chk("reset stall", {31'd0, stall_o}, 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset rd", {27'd0, rd_o}, 32'd0);
        step();
        rst = 1'b0;
        step();

        run_op("MUL",    3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, dummy);
        run_op("MULH",   3'b001, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34, dummy);
        run_op("MULHU",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34, dummy);
        run_op("MULHSU", 3'b010, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 34, dummy);
        run_op("DIV",    3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34, dummy);
        run_op("REM",    3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34, dummy);
        run_op("DIVU",   3'b101, 32'd100,        32'd7,         5'd11, 32'd14,        34, dummy);
        run_op("REMU",   3'b111, 32'd100,        32'd7,         5'd12, 32'd2,         34, dummy);
        run_op("DIVU/0", 3'b101, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 2,  dummy);
        run_op("REM/0",  3'b110, 32'd5,          32'd0,         5'd14, 32'd5,         2,  dummy);
        run_op("DIVovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 2,  dummy);
        run_op("REMovf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         2,  dummy);

        // flush during CALC: op dropped, result_o/rd_o keep REMovf values
        valid_i = 1'b1; funct3_i = 3'b100; op_a_i = 32'd1000; op_b_i = 32'd3; rd_i = 5'd20;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("flush busy before", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush busy after", {31'd0, busy_o}, 32'd0);
        saw_done = done_o;
        for (int i = 0; i < 40; i++) begin
            step();
            saw_done = saw_done | done_o;
        end
        chk("flush no done", {31'd0, saw_done}, 32'd0);
        chk("flush result kept", result_o, 32'd0);
        chk("flush rd kept", {27'd0, rd_o}, 32'd16);

        // flush has priority over valid in IDLE
        valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd3; op_b_i = 32'd3;
        #1;
        chk("flush prio stall", {31'd0, stall_o}, 32'd0);
        step();
        valid_i = 1'b0; flush_i = 1'b0;
        chk("flush prio busy", {31'd0, busy_o}, 32'd0);

        // async reset mid-CALC
        valid_i = 1'b1; funct3_i = 3'b000; op_a_i = 32'd9; op_b_i = 32'd9; rd_i = 5'd3;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 15; i++) step();
        #1 rst = 1'b1;
        #1;
        chk("async rst busy", {31'd0, busy_o}, 32'd0);
        chk("async rst done", {31'd0, done_o}, 32'd0);
        chk("async rst result", result_o, 32'd0);
        chk("async rst rd", {27'd0, rd_o}, 32'd0);
        chk("async rst stall", {31'd0, stall_o}, 32'd0);
        #1 rst = 1'b0;
        step();

        // back-to-back MULs: second issued in the cycle after DONE
        run_op("B2B MUL1", 3'b000, 32'd12345, 32'd678, 5'd21, 32'd8369910, 34, d1);
        run_op("B2B MUL2", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'd1, 34, d2);
        chk("B2B spacing", d2 - d1, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
